// File: rtl/flap_game_pkg.sv
// Shared definitions for the flapping-box game: state codes, screen bounds, score width.
// FLAP_GAME_PAUSE_EN adds the PAUSED state and widens the state code to 3 bits.
package flap_game_pkg;

`ifdef FLAP_GAME_PAUSE_EN
  localparam int STATE_W = 3;
`else
  localparam int STATE_W = 2;
`endif

  localparam logic [STATE_W-1:0] ST_IDLE      = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_START     = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_PLAYING   = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_GAME_OVER = STATE_W'(3);
`ifdef FLAP_GAME_PAUSE_EN
  localparam logic [STATE_W-1:0] ST_PAUSED    = STATE_W'(4);
`endif

  localparam int                 BOX_Y_W      = 7;
  localparam logic [BOX_Y_W-1:0] SCREEN_Y_MIN = 7'd0;
  localparam logic [BOX_Y_W-1:0] SCREEN_Y_MAX = 7'd119;

  localparam int SCORE_W = 8;

endpackage

// File: rtl/flap_game_controller_if.sv
// Signal bundle between the game controller and the key, box register and display.
// FLAP_GAME_PAUSE_EN adds the pause_in level.
interface flap_game_controller_if;
  import flap_game_pkg::*;

  logic               key_in;
  logic [BOX_Y_W-1:0] box_y;
`ifdef FLAP_GAME_PAUSE_EN
  logic               pause_in;
`endif
  logic               game_tick;
  logic               tap;
  logic               box_reset;
  logic [STATE_W-1:0] state;
  logic [SCORE_W-1:0] score;
  logic               game_over;

`ifdef FLAP_GAME_PAUSE_EN
  modport master (output key_in, box_y, pause_in,
                  input  game_tick, tap, box_reset, state, score, game_over);
  modport slave  (input  key_in, box_y, pause_in,
                  output game_tick, tap, box_reset, state, score, game_over);
`else
  modport master (output key_in, box_y,
                  input  game_tick, tap, box_reset, state, score, game_over);
  modport slave  (input  key_in, box_y,
                  output game_tick, tap, box_reset, state, score, game_over);
`endif

endinterface

// File: rtl/flap_tick_divider.sv
// Free-running 0..TICK_DIV-1 counter; tick is high while it sits on its last value.
// clear restarts from 0 so the next tick is exactly TICK_DIV cycles away; freeze holds the count.
module flap_tick_divider #(
  parameter int unsigned TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int               CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (!freeze) begin
      cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // A count frozen on its last value must not repeat the pulse every cycle.
  assign tick = (cnt_q == CNT_LAST) && !freeze;

endmodule

// File: rtl/flap_game_controller.sv
// Game sequencer: IDLE/START/PLAYING/GAME_OVER, tick and tap pulses, collision detect, score.
// FLAP_GAME_PAUSE_EN adds pause_in and a PAUSED state that freezes the game tick.
module flap_game_controller
  import flap_game_pkg::*;
#(
  parameter int unsigned        TICK_DIV    = 833333,
  parameter logic [BOX_Y_W-1:0] Y_MIN       = SCREEN_Y_MIN,
  parameter logic [BOX_Y_W-1:0] Y_MAX       = SCREEN_Y_MAX,
  parameter int unsigned        SCORE_TICKS = 30,
  parameter int unsigned        OVER_HOLD   = 60
) (
  input logic                   CLOCK_50,
  input logic                   reset,
  flap_game_controller_if.slave bus
);

  localparam int                 SUB_W     = $clog2(SCORE_TICKS + 1);
  localparam int                 HOLD_W    = $clog2(OVER_HOLD + 1);
  localparam logic [SUB_W-1:0]   SUB_LAST  = SUB_W'(SCORE_TICKS - 1);
  localparam logic [HOLD_W-1:0]  HOLD_END  = HOLD_W'(OVER_HOLD);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [STATE_W-1:0] state_q, state_d;
  logic               key_prev, key_edge;
  logic               tick_int, tick_clear, tick_freeze;
  logic               playing, collide, game_tick_int, hold_done;
  logic [SUB_W-1:0]   sub_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [SCORE_W-1:0] score_q;

  assign key_edge      = bus.key_in & ~key_prev;
  assign playing       = (state_q == ST_PLAYING);
  assign collide       = tick_int && ((bus.box_y <= Y_MIN) || (bus.box_y >= Y_MAX));
  assign game_tick_int = playing && tick_int && !collide;
  assign hold_done     = (hold_q == HOLD_END);
  assign tick_clear    = (state_q == ST_START);

`ifdef FLAP_GAME_PAUSE_EN
  logic pause_prev, pause_edge;
  assign pause_edge  = bus.pause_in & ~pause_prev;
  assign tick_freeze = (state_q == ST_PAUSED);

  always_ff @(posedge CLOCK_50) begin
    if (reset) pause_prev <= 1'b0;
    else       pause_prev <= bus.pause_in;
  end
`else
  assign tick_freeze = 1'b0;
`endif

  flap_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_divider (
    .clk    (CLOCK_50),
    .rst    (reset),
    .clear  (tick_clear),
    .freeze (tick_freeze),
    .tick   (tick_int)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (key_edge) state_d = ST_START;
      ST_START:     state_d = ST_PLAYING;
      ST_PLAYING: begin
        // A colliding tick ends the game even if a pause edge arrives with it.
        if (collide) state_d = ST_GAME_OVER;
`ifdef FLAP_GAME_PAUSE_EN
        else if (pause_edge) state_d = ST_PAUSED;
`endif
      end
      ST_GAME_OVER: if (key_edge && hold_done) state_d = ST_IDLE;
`ifdef FLAP_GAME_PAUSE_EN
      ST_PAUSED:    if (pause_edge) state_d = ST_PLAYING;
`endif
      default:      state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      key_prev <= 1'b0;
      sub_q    <= '0;
      hold_q   <= '0;
      score_q  <= '0;
    end else begin
      state_q  <= state_d;
      key_prev <= bus.key_in;

      if (state_q == ST_START) begin
        sub_q   <= '0;
        score_q <= '0;
      end else if (game_tick_int) begin
        if (sub_q == SUB_LAST) begin
          sub_q <= '0;
          if (score_q != SCORE_MAX) score_q <= score_q + 1'b1;
        end else begin
          sub_q <= sub_q + 1'b1;
        end
      end

      // Hold time restarts on every entry into GAME_OVER and saturates at OVER_HOLD.
      if (state_q != ST_GAME_OVER)      hold_q <= '0;
      else if (tick_int && !hold_done)  hold_q <= hold_q + 1'b1;
    end
  end

  assign bus.game_tick = game_tick_int;
  assign bus.tap       = playing && key_edge && !collide;
  assign bus.box_reset = (state_q == ST_IDLE) || (state_q == ST_START);
  assign bus.state     = state_q;
  assign bus.score     = score_q;
  assign bus.game_over = (state_q == ST_GAME_OVER);

endmodule

// File: tb/tb_flap_game_controller.sv
// Directed bench for flap_game_controller (TICK_DIV=4, SCORE_TICKS=2, OVER_HOLD=3);
// game_tick arrival cycles are checked against a queue of expected cycles.
module tb_flap_game_controller;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_ticks[$];

  flap_game_controller_if bus();

  flap_game_controller #(
    .TICK_DIV    (4),
    .Y_MIN       (7'd0),
    .Y_MAX       (7'd119),
    .SCORE_TICKS (2),
    .OVER_HOLD   (3)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Land 1 time unit after the posedge that starts cycle c.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (bus.game_tick === 1'b1) begin
      checks++;
      assert (exp_ticks.size() > 0)
      else begin
        errors++;
        $error("FAIL tick_unexpected: observed tick at cycle %0d expected none", cyc);
      end
      if (exp_ticks.size() > 0) check("tick_cycle", cyc, exp_ticks.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    bus.key_in = 1'b0;
    bus.box_y  = 7'd60;

    goto(1); #2;
    check("rst_state", bus.state, 0);
    check("rst_score", bus.score, 0);
    check("rst_game_tick", bus.game_tick, 0);
    check("rst_tap", bus.tap, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_box_reset", bus.box_reset, 1);
    goto(2); reset = 1'b0;

    // Game 1: start, taps, tick boundaries at y=118 and y=1, floor collision.
    goto(10); bus.key_in = 1'b1; #2;
    check("idle_state", bus.state, 0);
    check("idle_tap", bus.tap, 0);
    goto(11); #2;
    check("start_state", bus.state, 1);
    check("start_box_reset", bus.box_reset, 1);
    goto(12); bus.box_y = 7'd118;
    exp_ticks.push_back(15);
    exp_ticks.push_back(19);
    #2;
    check("play_state", bus.state, 2);
    check("play_box_reset", bus.box_reset, 0);
    check("play_score0", bus.score, 0);
    goto(13); bus.key_in = 1'b0;
    goto(14); bus.key_in = 1'b1; #2;
    check("tap_alone", bus.tap, 1);
    check("tap_alone_no_tick", bus.game_tick, 0);
    goto(16); bus.key_in = 1'b0; bus.box_y = 7'd1;
    goto(19); bus.key_in = 1'b1; #2;
    check("tap_with_tick", bus.tap, 1);
    check("tick_with_tap", bus.game_tick, 1);
    goto(20); bus.key_in = 1'b0; bus.box_y = 7'd119; #2;
    check("score_after_2_ticks", bus.score, 1);
    goto(23); bus.key_in = 1'b1; #2;
    check("collide_tap", bus.tap, 0);
    check("collide_tick", bus.game_tick, 0);
    check("collide_cycle_state", bus.state, 2);
    goto(24); #2;
    check("over_state", bus.state, 3);
    check("over_flag", bus.game_over, 1);
    check("over_box_reset", bus.box_reset, 0);
    check("over_score", bus.score, 1);
    goto(25); bus.key_in = 1'b0;
    goto(29); bus.key_in = 1'b1; #2;
    check("over_tap", bus.tap, 0);
    goto(30); bus.key_in = 1'b0; #2;
    check("early_key_ignored", bus.state, 3);
    goto(37); bus.key_in = 1'b1;
    goto(38); bus.key_in = 1'b0; #2;
    check("hold_key_idle", bus.state, 0);
    check("hold_key_box_reset", bus.box_reset, 1);
    check("hold_key_game_over", bus.game_over, 0);

    // Game 2: 600 ticks saturate the score, then ceiling collision.
    goto(40); bus.box_y = 7'd60; bus.key_in = 1'b1;
    goto(41); bus.key_in = 1'b0; #2;
    check("g2_start", bus.state, 1);
    goto(42);
    for (int k = 0; k < 600; k++) exp_ticks.push_back(45 + 4 * k);
    #2;
    check("g2_score_cleared", bus.score, 0);
    goto(2074); #2;
    check("score_254", bus.score, 254);
    goto(2082); #2;
    check("score_255", bus.score, 255);
    goto(2442); bus.box_y = 7'd0; #2;
    check("score_saturated", bus.score, 255);
    goto(2446); #2;
    check("ceiling_state", bus.state, 3);
    check("ceiling_score", bus.score, 255);
    goto(2450); reset = 1'b1;
    goto(2451); reset = 1'b0; #2;
    check("over_reset_state", bus.state, 0);
    check("over_reset_game_over", bus.game_over, 0);

    // Game 3: reach score 7, then reset mid-play.
    goto(2453); bus.box_y = 7'd60; bus.key_in = 1'b1;
    goto(2454); bus.key_in = 1'b0;
    goto(2455);
    for (int k = 0; k < 14; k++) exp_ticks.push_back(2458 + 4 * k);
    goto(2511); #2;
    check("g3_score7", bus.score, 7);
    goto(2512); reset = 1'b1;
    goto(2513); reset = 1'b0; #2;
    check("midplay_reset_state", bus.state, 0);
    check("midplay_reset_score", bus.score, 0);
    check("midplay_reset_box_reset", bus.box_reset, 1);
    check("midplay_reset_tick", bus.game_tick, 0);
    goto(2520); #2;
    check("after_reset_state", bus.state, 0);
    check("tick_queue_empty", exp_ticks.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
